sha256_msg_sequencer: RTL
=========================

// Module: sha256_msg_sequencer
// PURPOSE
//  Sequences the SHA-256 compression core for messages of arbitrary byte length.
//  - Accepts a stream of 32-bit big-endian message words from the Wishbone register front-end.
//  - Inserts the 0x80 pad byte, zero fill and the 64-bit bit-length field itself.
//  - Splits the message into 16-word blocks and chains the blocks through the core.
//  - Software therefore never pads by hand.
// PARAMETERS
//  LEN_W   32   width of message byte counter; max message = 2^LEN_W-1 bytes
// PORTS
//  wb_clk_i        in   1   clock
//  wb_rst_i        in   1   reset, asynchronous, active-high
//  msg_start       in   1   1-cycle pulse: begin new message (ignored unless idle)
//  msg_valid       in   1   msg_data/msg_last/msg_bytes valid
//  msg_ready       out  1   word accepted when msg_valid & msg_ready
//  msg_data        in   32  message word, first byte in [31:24]
//  msg_last        in   1   final word of message
//  msg_bytes       in   3   valid bytes in final word, 0..4 (ignored unless msg_last)
//  core_first      out  1   high with every word of the first block (core loads IV)
//  core_wvalid     out  1   word to core valid
//  core_wready     in   1   core accepts word
//  core_wdata      out  32  word to core
//  core_block_done in   1   1-cycle pulse: compression of current block finished
//  busy            out  1   message in progress
//  done            out  1   1-cycle pulse: digest of final block valid in core
//  err             out  1   sticky protocol error; cleared by an accepted msg_start
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; word index, byte count and first flag cleared.
//  - A reset mid-message aborts the message; no done pulse is produced.
//  - States: IDLE -> DATA -> PAD -> ZERO -> LENHI -> LENLO -> WAIT -> DONE -> IDLE.
//    - WAIT is also entered after word 15 of any block.
//  - IDLE
//    - msg_start: clear err, byte count and word index (widx); set first.
//    - Next state DATA; busy=1 from the next cycle.
//  - DATA
//    - Passthrough: msg_ready = core_wready, core_wvalid = msg_valid, both combinational.
//    - Non-last word: core_wdata = msg_data; byte count += 4.
//    - Last word with n = msg_bytes < 4:
//      - Bytes n..3 are replaced by 0x80 followed by zeros.
//      - Example: n=3 gives {d[31:8],8'h80}.
//      - Byte count += n.
//    - Last word with n = 4: the word passes unchanged; byte count += 4; go to PAD.
//    - Last word with n = 0: no data is sent; go to PAD.
//    - msg_bytes > 4: err=1, the word is treated as n=4.
//  - PAD
//    - Emits 0x80000000 (core_wvalid=1, msg_ready=0).
//  - ZERO
//    - Emits 0x00000000 until widx = 14, then LENHI.
//    - If the pad word landed at widx 14 or 15:
//      - Zero-fill to widx 15, then WAIT.
//      - The next block restarts in ZERO at widx 0 and fills to widx 13.
//  - LENHI / LENLO
//    - LENHI emits the upper 32 bits of {count,3'b0} zero-extended to 64 bits.
//    - LENLO emits the lower 32 bits of the same value.
//  - Every core word transfer (core_wvalid & core_wready) increments widx mod 16.
//  - When the transfer at widx 15 completes:
//    - first is cleared.
//    - Next state WAIT, with msg_ready=0 and core_wvalid=0.
//  - WAIT
//    - On core_block_done, return to the interrupted phase (DATA or ZERO).
//    - After the final block, go to DONE instead.
//  - DONE: done=1 for one cycle, busy=0 on the next cycle, state IDLE.
//  - core_wdata holds its value while core_wvalid & !core_wready (no drop, no duplicate).
//  - Byte count overflow past 2^LEN_W-1: err=1; the count wraps and the hash still completes.
//  - msg_start while busy: ignored, err=1.
//  - msg_valid in IDLE: msg_ready=0, no effect.
//  - core_block_done outside WAIT: ignored, err=1.
// TESTING
//  1. "abc": start; one word 0x61626300, last, bytes=3.
//     Core sees 0x61626380, 13 zero words, 0x00000000, 0x00000018.
//     core_first high on all 16 words; one block; done once.
//  2. 55-byte message: 13 full words + 0x69556C00 (bytes=3).
//     Word 13 = 0x69556C80, word 14 = 0, word 15 = 0x000001B8.
//     Single block; digest 2BFC20BF...CFA7562E.
//  3. 56-byte message: 14 full words + terminator (bytes=0).
//     Block 1 words 14..15 = 0x80000000, 0.
//     Block 2 = 14 zero words, 0, 0x000001C0.
//     core_first low in block 2; done after the 2nd core_block_done.
//  4. Empty message (first word last, bytes=0): 0x80000000, 15 zero words; length 0.
//  5. Backpressure: core_wready random 50% during test 3.
//     Word sequence identical; msg_ready=0 throughout WAIT.
//  6. Errors/reset:
//     - bytes=5 -> err=1, the word is treated as 4 bytes.
//     - msg_start while busy -> err=1, ignored.
//     - wb_rst_i at widx 7 -> all outputs 0, no done pulse; a new message then hashes correctly.

Source files
------------

// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: feeds the SHA-256 compression core from a message word
// stream. It appends the 0x80 pad byte, the zero fill and the 64-bit bit length,
// and splits the result into 16-word blocks chained through the core.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   msg_start                 pulse: begin a new message (accepted only when idle)
//   msg_valid/msg_ready       message word handshake
//   msg_data/msg_last/msg_bytes  word, final-word flag, valid bytes in final word
//   core_first                high for every word of the first block
//   core_wvalid/core_wready   core word handshake, core_wdata is the word
//   core_block_done           pulse: core finished compressing the current block
//   busy, done, err           status: message in progress, digest valid, sticky error
module sha256_msg_sequencer #(
    parameter int unsigned LEN_W = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        msg_start,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_data,
    input  logic        msg_last,
    input  logic [2:0]  msg_bytes,
    output logic        core_first,
    output logic        core_wvalid,
    input  logic        core_wready,
    output logic [31:0] core_wdata,
    input  logic        core_block_done,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CW = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_PAD, S_ZERO, S_LENHI, S_LENLO, S_WAIT, S_DONE
    } state_t;

    state_t           state, state_nx, ret_q, ret_nx, phase_nx;
    logic [3:0]       widx_q, widx_nx;
    logic [LEN_W-1:0] cnt_q, cnt_nx;
    logic [CW-1:0]    cnt_sum;
    logic [2:0]       add, n_eff;
    logic [63:0]      len_bits;
    logic             first_q, first_nx, err_nx, done_nx, xfer;

    // Phase following a word that holds the pad byte (or a zero-fill word) at widx w:
    // leave two slots for the length, or spill the length into the next block.
    function automatic state_t fill_next(input logic [3:0] w);
        if (w == 4'd13) return S_LENHI;
        return S_ZERO;
    endfunction

    // Final data word with n valid bytes: pad byte right after the data.
    function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [2:0] n);
        case (n)
            3'd1:    return {d[31:24], 24'h80_0000};
            3'd2:    return {d[31:16], 16'h8000};
            3'd3:    return {d[31:8], 8'h80};
            default: return d;
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            ret_q   <= S_DATA;
            widx_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            ret_q   <= ret_nx;
            widx_q  <= widx_nx;
            cnt_q   <= cnt_nx;
            first_q <= first_nx;
            err     <= err_nx;
            done    <= done_nx;
            busy    <= (state_nx != S_IDLE);
        end
    end

    assign core_first = first_q;

    // Next state, word mux and handshake
    always_comb begin
        state_nx    = state;
        ret_nx      = ret_q;
        phase_nx    = state;
        widx_nx     = widx_q;
        cnt_nx      = cnt_q;
        cnt_sum     = '0;
        first_nx    = first_q;
        err_nx      = err;
        done_nx     = 1'b0;
        msg_ready   = 1'b0;
        core_wvalid = 1'b0;
        core_wdata  = '0;
        add         = 3'd0;
        n_eff       = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
        len_bits    = 64'({cnt_q, 3'b000});

        case (state)
            S_IDLE: begin
                if (msg_start) begin
                    state_nx = S_DATA;
                    err_nx   = 1'b0;
                    cnt_nx   = '0;
                    widx_nx  = '0;
                    first_nx = 1'b1;
                end
            end
            S_DATA: begin
                if (msg_last && n_eff == 3'd0) begin
                    // Empty terminator: consumed without a core transfer
                    msg_ready = 1'b1;
                    if (msg_valid) state_nx = S_PAD;
                end else begin
                    msg_ready   = core_wready;
                    core_wvalid = msg_valid;
                    core_wdata  = pad_word(msg_data, msg_last ? n_eff : 3'd4);
                    if (!msg_last) begin
                        add      = 3'd4;
                        phase_nx = S_DATA;
                    end else if (n_eff == 3'd4) begin
                        add      = 3'd4;
                        phase_nx = S_PAD;
                    end else begin
                        add      = n_eff;
                        phase_nx = fill_next(widx_q);
                    end
                    if (msg_valid && core_wready && msg_last && msg_bytes > 3'd4)
                        err_nx = 1'b1;
                end
            end
            S_PAD: begin
                core_wvalid = 1'b1;
                core_wdata  = 32'h8000_0000;
                phase_nx    = fill_next(widx_q);
            end
            S_ZERO: begin
                core_wvalid = 1'b1;
                phase_nx    = fill_next(widx_q);
            end
            S_LENHI: begin
                core_wvalid = 1'b1;
                core_wdata  = len_bits[63:32];
                phase_nx    = S_LENLO;
            end
            S_LENLO: begin
                core_wvalid = 1'b1;
                core_wdata  = len_bits[31:0];
                phase_nx    = S_DONE;
            end
            S_WAIT: begin
                if (core_block_done) begin
                    state_nx = ret_q;
                    done_nx  = (ret_q == S_DONE);
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        xfer = core_wvalid && core_wready;
        if (xfer) begin
            widx_nx = widx_q + 4'd1;
            cnt_sum = {1'b0, cnt_q} + CW'(add);
            cnt_nx  = cnt_sum[LEN_W-1:0];
            if (cnt_sum[LEN_W]) err_nx = 1'b1;
            // Block boundary: park in WAIT, remember where to resume
            if (widx_q == 4'd15) begin
                state_nx = S_WAIT;
                ret_nx   = phase_nx;
                first_nx = 1'b0;
            end else begin
                state_nx = phase_nx;
            end
        end

        if (msg_start && state != S_IDLE) err_nx = 1'b1;
        if (core_block_done && state != S_WAIT) err_nx = 1'b1;
    end

endmodule
